bip_data_memory: RTL and testbench

//  Parametrised data RAM for the BIP datapath, next generation of the 8-word data memory.

---
 rtl/bip_data_memory_pkg.sv | 13 +
 rtl/dmem_clear_seq.sv | 65 ++++++
 rtl/bip_data_memory.sv | 117 +++++++++++
 tb/tb_bip_data_memory.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/bip_data_memory_pkg.sv
// -----------------------------------------------------------------------------
// bip_data_memory_pkg
// Shared declarations for the BIP data memory.
//   dmem_state_e : controller state (ST_CLEAR = sweeping zeros, ST_READY = serving CPU)
// -----------------------------------------------------------------------------
package bip_data_memory_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } dmem_state_e;

endpackage

// File: rtl/dmem_clear_seq.sv
// -----------------------------------------------------------------------------
// dmem_clear_seq
// Post-reset clear sequencer for the BIP data memory. After reset it walks an
// index from 0 to N_DATOS-1, one word per clock, then parks in ST_READY until
// the next reset.
// Ports:
//   i_clk      clock, rising edge
//   i_reset    synchronous active-low reset (0 = reset)
//   o_clr_idx  word index being cleared this cycle
//   o_clr_we   1 while a clear write is pending for o_clr_idx
//   o_busy     1 while the sweep is in progress
// -----------------------------------------------------------------------------
module dmem_clear_seq
  import bip_data_memory_pkg::*;
#(
  parameter  int N_DATOS = 16,
  localparam int NB_IDX  = $clog2(N_DATOS)
) (
  input  logic              i_clk,
  input  logic              i_reset,
  output logic [NB_IDX-1:0] o_clr_idx,
  output logic              o_clr_we,
  output logic              o_busy
);

  localparam logic [NB_IDX-1:0] LAST_IDX = NB_IDX'(N_DATOS - 1);

  dmem_state_e       r_state;
  dmem_state_e       w_next_state;
  logic [NB_IDX-1:0] r_idx;
  logic [NB_IDX-1:0] w_next_idx;

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state <= ST_CLEAR;
      r_idx   <= '0;
    end else begin
      r_state <= w_next_state;
      r_idx   <= w_next_idx;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_next_idx   = r_idx;
    o_clr_we     = 1'b0;
    case (r_state)
      ST_CLEAR: begin
        o_clr_we   = 1'b1;
        w_next_idx = r_idx + 1'b1;
        if (r_idx == LAST_IDX) begin
          w_next_state = ST_READY;
        end
      end
      default: begin
        // READY is left only through reset
        w_next_state = ST_READY;
      end
    endcase
  end

  assign o_clr_idx = r_idx;
  assign o_busy    = (r_state == ST_CLEAR);

endmodule

// File: rtl/bip_data_memory.sv
// -----------------------------------------------------------------------------
// bip_data_memory
// Parametrised data RAM for the BIP datapath. Clears itself after reset
// (o_busy high for N_DATOS cycles), then accepts one read and/or write per
// cycle. Reads have one cycle of latency and are read-before-write against a
// write to the same word in the same cycle. Addresses with any bit set above
// the index field are out of range: the write is dropped, a read returns 0,
// and o_addr_err pulses.
// Build option: define DMEM_DEBUG_PORT_EN to add a combinational debug read
// port (i_dbg_addr / o_dbg_data) that does not disturb the CPU port.
// Ports:
//   i_clk, i_reset           clock / synchronous active-low reset
//   i_address, i_data        CPU word address / write data
//   i_wr, i_rd               CPU write / read request
//   o_data                   registered read data (signed)
//   o_valid                  pulse: o_data updated by a read
//   o_busy                   clear sweep in progress, requests ignored
//   o_addr_err               pulse: accepted request was out of range
//   i_dbg_addr, o_dbg_data   debug read port (DMEM_DEBUG_PORT_EN only)
// -----------------------------------------------------------------------------
module bip_data_memory
  import bip_data_memory_pkg::*;
#(
  parameter  int NB_DATA = 16,
  parameter  int NB_ADDR = 11,
  parameter  int N_DATOS = 16,
  localparam int NB_IDX  = $clog2(N_DATOS)
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic [NB_ADDR-1:0]        i_address,
  input  logic [NB_DATA-1:0]        i_data,
  input  logic                      i_wr,
  input  logic                      i_rd,
  output logic signed [NB_DATA-1:0] o_data,
  output logic                      o_valid,
  output logic                      o_busy,
  output logic                      o_addr_err
`ifdef DMEM_DEBUG_PORT_EN
  ,
  input  logic [NB_ADDR-1:0]        i_dbg_addr,
  output logic [NB_DATA-1:0]        o_dbg_data
`endif
);

  logic [NB_DATA-1:0]        r_mem [N_DATOS];
  logic [NB_IDX-1:0]         w_clr_idx;
  logic                      w_clr_we;
  logic                      w_busy;
  logic                      w_ready;
  logic [NB_IDX-1:0]         w_idx;
  logic                      w_in_range;
  logic [NB_DATA-1:0]        w_rd_word;
  logic signed [NB_DATA-1:0] r_rd_data_p1;
  logic                      r_valid_p1;
  logic                      r_addr_err_p1;

  dmem_clear_seq #(
    .N_DATOS (N_DATOS)
  ) u_clear_seq (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .o_clr_idx (w_clr_idx),
    .o_clr_we  (w_clr_we),
    .o_busy    (w_busy)
  );

  assign w_ready    = ~w_busy;
  assign w_idx      = i_address[NB_IDX-1:0];
  // Shift form stays legal when the index covers the whole address
  assign w_in_range = ((i_address >> NB_IDX) == '0);
  assign w_rd_word  = w_in_range ? r_mem[w_idx] : '0;

  // Clear sweep has priority; the two sources never overlap since CPU
  // writes are only accepted once the sweep has finished.
  always_ff @(posedge i_clk) begin
    if (i_reset && w_clr_we) begin
      r_mem[w_clr_idx] <= '0;
    end else if (i_reset && w_ready && i_wr && w_in_range) begin
      r_mem[w_idx] <= i_data;
    end
  end

  // ---- stage p1: read register and strobes ----
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_rd_data_p1  <= '0;
      r_valid_p1    <= 1'b0;
      r_addr_err_p1 <= 1'b0;
    end else begin
      r_valid_p1    <= 1'b0;
      r_addr_err_p1 <= 1'b0;
      if (w_ready && (i_rd || i_wr)) begin
        r_addr_err_p1 <= ~w_in_range;
        if (i_rd) begin
          r_rd_data_p1 <= w_rd_word;
          r_valid_p1   <= 1'b1;
        end
      end
    end
  end

  assign o_data     = r_rd_data_p1;
  assign o_valid    = r_valid_p1;
  assign o_addr_err = r_addr_err_p1;
  assign o_busy     = w_busy;

`ifdef DMEM_DEBUG_PORT_EN
  logic [NB_IDX-1:0] w_dbg_idx;
  logic              w_dbg_in_range;

  assign w_dbg_idx      = i_dbg_addr[NB_IDX-1:0];
  assign w_dbg_in_range = ((i_dbg_addr >> NB_IDX) == '0);
  assign o_dbg_data     = w_dbg_in_range ? r_mem[w_dbg_idx] : '0;
`endif

endmodule

// File: tb/tb_bip_data_memory.sv
module tb_bip_data_memory;

  localparam int NB_DATA = 16;
  localparam int NB_ADDR = 11;
  localparam int N_DATOS = 16;

  logic               clk;
  logic               rst_n;
  logic [NB_ADDR-1:0] address;
  logic [NB_DATA-1:0] wdata;
  logic               wr;
  logic               rd;
  logic [NB_DATA-1:0] rdata;
  logic               valid;
  logic               busy;
  logic               addr_err;
`ifdef DMEM_DEBUG_PORT_EN
  logic [NB_ADDR-1:0] dbg_addr;
  logic [NB_DATA-1:0] dbg_data;
`endif

  bip_data_memory #(
    .NB_DATA (NB_DATA),
    .NB_ADDR (NB_ADDR),
    .N_DATOS (N_DATOS)
  ) dut (
    .i_clk      (clk),
    .i_reset    (rst_n),
    .i_address  (address),
    .i_data     (wdata),
    .i_wr       (wr),
    .i_rd       (rd),
    .o_data     (rdata),
    .o_valid    (valid),
    .o_busy     (busy),
    .o_addr_err (addr_err)
`ifdef DMEM_DEBUG_PORT_EN
    ,
    .i_dbg_addr (dbg_addr),
    .o_dbg_data (dbg_data)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: memory contents, remaining clear cycles, expected outputs
  logic [NB_DATA-1:0] m_mem [N_DATOS];
  int                 m_clear_left;
  logic [NB_DATA-1:0] m_data;
  logic               m_valid;
  logic               m_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Model one rising edge from the spec's rules
  task automatic model_edge();
    int a;
    a = int'(address);
    if (!rst_n) begin
      m_data = '0; m_valid = 1'b0; m_err = 1'b0;
      m_clear_left = N_DATOS;
      foreach (m_mem[i]) m_mem[i] = '0;
    end else if (m_clear_left > 0) begin
      m_clear_left--;
      m_valid = 1'b0; m_err = 1'b0;
    end else begin
      m_err   = (rd || wr) && (a >= N_DATOS);
      m_valid = rd;
      if (rd) m_data = (a < N_DATOS) ? m_mem[a] : '0;
      if (wr && a < N_DATOS) m_mem[a] = wdata;
    end
  endtask

  // Drive inputs, take one edge, check all CPU outputs against the model
  task automatic cyc(input string tag, input logic r, input int a, input logic [15:0] d,
                     input logic w, input logic rr);
    rst_n   = r;
    address = NB_ADDR'(a);
    wdata   = d;
    wr      = w;
    rd      = rr;
    @(posedge clk);
    model_edge();
    #1;
    chk({tag, ".busy"},  32'(busy),     32'(m_clear_left > 0));
    chk({tag, ".valid"}, 32'(valid),    32'(m_valid));
    chk({tag, ".err"},   32'(addr_err), 32'(m_err));
    chk({tag, ".data"},  32'(rdata),    32'(m_data));
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) cyc(tag, 1'b1, 0, 16'h0, 1'b0, 1'b0);
  endtask

  initial begin
    int busy_edges;
    rst_n = 1'b0; address = '0; wdata = '0; wr = 1'b0; rd = 1'b0;
    m_clear_left = N_DATOS; m_data = '0; m_valid = 1'b0; m_err = 1'b0;
    foreach (m_mem[i]) m_mem[i] = '0;
`ifdef DMEM_DEBUG_PORT_EN
    dbg_addr = '0;
`endif

    // Reset state
    cyc("rst", 1'b0, 0, 16'h0, 1'b0, 1'b0);
    cyc("rst", 1'b0, 0, 16'h0, 1'b0, 1'b0);
    chk("rst.busy_const", 32'(busy), 32'd1);

    // T1: count busy edges directly, then read every word
    busy_edges = 0;
    for (int i = 0; i < 20; i++) begin
      cyc("t1.idle", 1'b1, 0, 16'h0, 1'b0, 1'b0);
      if (busy) busy_edges++;
    end
    chk("t1.busy_edges", 32'(busy_edges + 1), 32'(N_DATOS));
    for (int i = 0; i < N_DATOS; i++) begin
      cyc("t1.rd", 1'b1, i, 16'h0, 1'b0, 1'b1);
      chk("t1.zero", 32'(rdata), 32'h0);
    end

    // T2: write then read
    cyc("t2.wr", 1'b1, 5, 16'h1234, 1'b1, 1'b0);
    chk("t2.novalid", 32'(valid), 32'd0);
    cyc("t2.rd", 1'b1, 5, 16'h0, 1'b0, 1'b1);
    chk("t2.data", 32'(rdata), 32'h1234);
    idle("t2.idle", 1);
    chk("t2.valid_drop", 32'(valid), 32'd0);

    // T3: read-before-write on the same word
    cyc("t3.rdwr", 1'b1, 5, 16'hBEEF, 1'b1, 1'b1);
    chk("t3.old", 32'(rdata), 32'h1234);
    cyc("t3.rd", 1'b1, 5, 16'h0, 1'b0, 1'b1);
    chk("t3.new", 32'(rdata), 32'hBEEF);

    // T4: out-of-range accesses
    cyc("t4.wr_oor", 1'b1, 'h010, 16'h5555, 1'b1, 1'b0);
    chk("t4.err", 32'(addr_err), 32'd1);
    cyc("t4.rd0", 1'b1, 0, 16'h0, 1'b0, 1'b1);
    chk("t4.word0", 32'(rdata), 32'h0);
    chk("t4.err_pulse", 32'(addr_err), 32'd0);
    cyc("t4.rd_oor", 1'b1, 'h7FF, 16'h0, 1'b0, 1'b1);
    chk("t4.oor_data", 32'(rdata), 32'h0);
    chk("t4.oor_err", 32'(addr_err), 32'd1);

`ifdef DMEM_DEBUG_PORT_EN
    // T6: debug read port
    cyc("t6.wr", 1'b1, 3, 16'hA5A5, 1'b1, 1'b0);
    dbg_addr = 11'd3;
    #1;
    chk("t6.dbg3", 32'(dbg_data), 32'hA5A5);
    dbg_addr = 11'h100;
    #1;
    chk("t6.dbg_oor", 32'(dbg_data), 32'h0);
`endif

    // T5: reset mid-clear, requests while busy are ignored
    cyc("t5.rst", 1'b0, 0, 16'h0, 1'b0, 1'b0);
    idle("t5.part", 7);
    cyc("t5.rst2", 1'b0, 0, 16'h0, 1'b0, 1'b0);
    busy_edges = 0;
    for (int i = 0; i < N_DATOS; i++) begin
      cyc("t5.busyreq", 1'b1, i, 16'hFFFF - 16'(i), 1'b1, 1'b1);
      if (busy) busy_edges++;
    end
    chk("t5.busy_edges", 32'(busy_edges + 1), 32'(N_DATOS));
    for (int i = 0; i < N_DATOS; i++) cyc("t5.rd", 1'b1, i, 16'h0, 1'b0, 1'b1);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      int a;
      logic r;
      r = ($urandom_range(0, 149) != 0);
      a = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 2047))
                                      : int'($urandom_range(0, N_DATOS - 1));
      cyc("rnd", r, a, 16'($urandom), 1'($urandom), 1'($urandom));
`ifdef DMEM_DEBUG_PORT_EN
      if (m_clear_left == 0) begin
        a = int'($urandom_range(0, N_DATOS - 1));
        dbg_addr = NB_ADDR'(a);
        #1;
        chk("rnd.dbg", 32'(dbg_data), 32'(m_mem[a]));
      end
`endif
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
